spi_slave_if: RTL

SPI responder (slave) that recovers frames driven by an external SPI master and returns a word on MISO in the same frame. Sits at the chip boundary in front of the datapath: received words go to the 32-bit arithmetic block's operand inputs; results come back through the transmit buffer. Mode 0 only (CPOL=0, CPHA=0), MSB first. All SPI pins are sampled into the single system clock domain.

---
 rtl/spi_slave_if_pkg.sv | 20 ++
 rtl/spi_slave_if_edge_sync.sv | 33 +++
 rtl/spi_slave_if.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if_pkg.sv
// Shared definitions for the SPI responder: word width, FSM states and SPI mode codes.
`timescale 1ns/1ps
package spi_slave_if_pkg;

  // Frame and word width; matches the operand width of the 32-bit arithmetic block.
  localparam int SPI_DATA_W = 32;

  // Frame tracking states: IDLE while deselected, ACTIVE while a frame is in progress.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // SPI mode codes as {CPOL, CPHA}; only mode 0 is wired up in the responder.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_if_edge_sync.sv
// Two-flop synchronizer plus one edge register, producing single-cycle rise/fall strobes.
`timescale 1ns/1ps
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Bring the pin into the clock domain and keep last cycle's value for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_if.sv
// Mode-0 SPI responder: receives a DATA_W-bit word on MOSI while returning the buffered TX word on MISO.
`timescale 1ns/1ps
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_sclk,
  input  logic              io_cs_n,
  input  logic              io_mosi,
  output logic              io_miso,
  input  logic [DATA_W-1:0] io_tx_data,
  input  logic              io_tx_valid,
  output logic              io_tx_ready,
  output logic [DATA_W-1:0] io_rx_data,
  output logic              io_rx_valid,
  output logic              io_underrun,
  output logic              io_busy
);

  localparam logic [1:0] MODE  = SPI_MODE0;
  localparam int         CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic mosi_meta, mosi_sync;

  logic sample_edge, shift_edge;
  logic active, frame_done, load, tx_accept;

  state_t state, state_next;

  logic [DATA_W-1:0] tx_buf;
  logic              buf_full;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic              skip_fall;

  spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clock (clock),
    .reset (reset),
    .din   (io_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_edge_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clock (clock),
    .reset (reset),
    .din   (io_cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI only needs the synchronizer; it is sampled on the detected sclk edge, which has the same age.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= io_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign sample_edge = MODE[1] ? sclk_fall : sclk_rise;
  assign shift_edge  = MODE[1] ? sclk_rise : sclk_fall;
  assign active      = (state == ACTIVE);
  assign frame_done  = active && sample_edge && (bit_cnt == LAST_BIT);
  // Reload at selection and at every completed word unless the master is releasing cs_n in the same cycle.
  assign load        = ((state == IDLE) && cs_fall) || (frame_done && !cs_rise);
  assign tx_accept   = io_tx_valid && !buf_full;
  assign io_tx_ready = ~buf_full;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: select starts a frame, deselect ends it from any bit position.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin outputs: MISO carries the shift register MSB only while selected.
  always_comb begin
    io_miso = 1'b0;
    io_busy = 1'b0;
    if (active) begin
      io_miso = tx_shift[DATA_W-1];
      io_busy = 1'b1;
    end
  end

  // One-entry TX buffer; a word written during a load cycle is kept for the following load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_buf   <= '0;
      buf_full <= 1'b0;
    end else if (tx_accept) begin
      tx_buf   <= io_tx_data;
      buf_full <= 1'b1;
    end else if (load && buf_full) begin
      buf_full <= 1'b0;
    end
  end

  // TX shift register: load from the buffer (or zeros on underrun), then shift on each trailing sclk edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_shift    <= '0;
      io_underrun <= 1'b0;
    end else begin
      io_underrun <= load && !buf_full;
      if (load) begin
        tx_shift <= buf_full ? tx_buf : '0;
      end else if (active && cs_rise) begin
        tx_shift <= '0;
      end else if (active && shift_edge && !skip_fall) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  // The trailing edge right after a completed word must not shift away the freshly loaded MSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skip_fall <= 1'b0;
    end else if (!active || cs_rise) begin
      skip_fall <= 1'b0;
    end else if (frame_done) begin
      skip_fall <= 1'b1;
    end else if (shift_edge) begin
      skip_fall <= 1'b0;
    end
  end

  // Receive path: shift MOSI in on each sampling edge and publish the word when the count wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_shift    <= '0;
      bit_cnt     <= '0;
      io_rx_data  <= '0;
      io_rx_valid <= 1'b0;
    end else begin
      io_rx_valid <= frame_done;
      if (frame_done) begin
        io_rx_data <= {rx_shift[DATA_W-2:0], mosi_sync};
      end
      if (!active || cs_rise || frame_done) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync};
        bit_cnt  <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
